// File: rtl/pst_if_pkg.sv
// Shared fetch-stage types and sizing for pst_if and its queue.
// FETCH_DEPTH is both the queue depth and the outstanding-request limit.
package pst_if_pkg;
   localparam int unsigned XLEN         = 32;
   localparam int unsigned FETCH_DEPTH  = 2;
   localparam int unsigned INFLIGHT_BIT = 2;

   typedef logic [XLEN-1:0] word_t;

   typedef struct packed {
      word_t inst;
      word_t pc;
   } fetch_entry_t;

   function automatic word_t word_align(input word_t a);
      return a & ~word_t'(3);
   endfunction
endpackage

// File: rtl/syn_fetch_fifo.sv
// Small {inst, pc} FIFO between the fetch credit logic and decode.
// Flush wins over push/pop; storage itself is not reset.
module syn_fetch_fifo
   import pst_if_pkg::*;
(
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                push_i,
   input  fetch_entry_t                        push_data_i,
   input  logic                                pop_i,
   input  logic                                flush_i,
   output fetch_entry_t                        head_o,
   output logic [$clog2(FETCH_DEPTH+1)-1:0]    count_o
);
   localparam int unsigned PTR_W = $clog2(FETCH_DEPTH);
   localparam int unsigned CNT_W = $clog2(FETCH_DEPTH+1);

   fetch_entry_t     mem_q [FETCH_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

// File: rtl/pst_if.sv
// Instruction fetch stage: PC, request credits, stale-response dropping,
// sticky halt, and a 2-entry queue feeding decode.
module pst_if
   import pst_if_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        im_req_valid,
   output logic [31:0] im_req_addr,
   input  logic        im_req_ready,
   input  logic        im_resp_valid,
   input  logic [31:0] im_resp_inst,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_4,
   input  logic        id_ready,
   output logic        halted
);
   localparam int unsigned CNT_W = $clog2(FETCH_DEPTH+1);

   word_t                   pc_q, pc_d;
   word_t                   resp_pc_q, resp_pc_d;
   logic [INFLIGHT_BIT-1:0] inflight_q, inflight_d;
   logic [INFLIGHT_BIT-1:0] drop_q, drop_d;
   logic                    halted_q, halted_d;

   logic [INFLIGHT_BIT-1:0] live;
   logic [INFLIGHT_BIT:0]   credits_used;
   logic [CNT_W-1:0]        q_count;
   fetch_entry_t            q_head;
   fetch_entry_t            push_entry;
   logic                    req_fire, drop_resp, push, pop;

   // Live in-flight words plus queued words must fit the queue, so a push never overflows.
   assign live         = inflight_q - drop_q;
   assign credits_used = {1'b0, live} + (INFLIGHT_BIT+1)'(q_count);

   assign im_req_valid = ~rst & en & ~halted_q & ~redirect_valid
                       & (inflight_q < INFLIGHT_BIT'(FETCH_DEPTH))
                       & (credits_used < (INFLIGHT_BIT+1)'(FETCH_DEPTH));
   assign im_req_addr  = rst ? PC_RESET : pc_q;
   assign req_fire     = im_req_valid & im_req_ready;

   assign drop_resp  = im_resp_valid & (redirect_valid | (drop_q != '0));
   assign push       = im_resp_valid & ~drop_resp;
   assign push_entry = '{inst: im_resp_inst, pc: resp_pc_q};

   assign id_valid = ~rst & en & (q_count != '0) & ~redirect_valid;
   assign pop      = id_valid & id_ready;
   assign id_inst  = q_head.inst;
   assign id_pc    = q_head.pc;
   assign id_pc_4  = q_head.pc + 32'd4;
   assign halted   = halted_q & ~rst;

   always_comb begin
      pc_d       = pc_q;
      resp_pc_d  = resp_pc_q;
      halted_d   = halted_q;
      drop_d     = drop_q;
      inflight_d = inflight_q - INFLIGHT_BIT'(im_resp_valid);
      if (en && halt) begin
         halted_d = 1'b1;
      end
      if (redirect_valid) begin
         // Every request still outstanding after this cycle's response is stale.
         pc_d      = word_align(redirect_pc);
         resp_pc_d = word_align(redirect_pc);
         drop_d    = inflight_d;
      end else begin
         if (req_fire) begin
            pc_d       = pc_q + 32'd4;
            inflight_d = inflight_d + INFLIGHT_BIT'(1);
         end
         if (drop_resp) begin
            drop_d = drop_q - INFLIGHT_BIT'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= PC_RESET;
         resp_pc_q  <= PC_RESET;
         inflight_q <= '0;
         drop_q     <= '0;
         halted_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         halted_q   <= halted_d;
      end
   end

   syn_fetch_fifo u_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect_valid),
      .head_o      (q_head),
      .count_o     (q_count)
   );
endmodule
